// File: rtl/cmd_decoder.sv
// cmd_decoder: parses escaped host command frames into config registers/strobes
// and forwards length-prefixed payloads to the target-side uart_tx.
module cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 24000,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_rdy,
    output logic [7:0]  width,
    output logic [7:0]  pulse_cnt,
    output logic [31:0] delay,
    output logic        sys_rst_req,
    output logic        board_rst_req,
    output logic        glitch_arm,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, CMD, ARG, PASS} state_t;
    state_t r_state, w_next;
    logic [7:0]      r_op, r_rem, r_buf, r_width, r_pcnt;
    logic [31:0]     r_delay;
    logic [TO_W-1:0] r_to;
    logic [1:0]      r_gcnt;
    logic            r_full, r_low, r_sys, r_board, r_arm, r_ovr;
    logic            w_tout, w_fire, w_arg_op;
    assign w_tout   = r_state != IDLE && !rx_valid && r_to == TO_W'(TIMEOUT_CYCLES);
    // Hold-off after a load: at least 2 cycles and a full low->high cycle of tx_rdy.
    assign w_fire   = r_full && tx_rdy && r_low && r_gcnt == 2'd2;
    assign w_arg_op = rx_data inside {8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23};
    assign tx_en         = w_fire;
    assign tx_data       = r_buf;
    assign width         = r_width;
    assign pulse_cnt     = r_pcnt;
    assign delay         = r_delay;
    assign sys_rst_req   = r_sys;
    assign board_rst_req = r_board;
    assign glitch_arm    = r_arm;
    assign overrun       = r_ovr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_tout) w_next = IDLE;
        else begin
            case (r_state)
                IDLE:    if (rx_valid) w_next = rx_data == 8'h00 ? CMD : PASS;
                CMD:     if (rx_valid) w_next = w_arg_op ? ARG : IDLE;
                ARG:     if (rx_valid) w_next = IDLE;
                default: if (r_rem == 8'h00 && !r_full) w_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_rem   <= '0;
            r_buf   <= '0;
            r_width <= '0;
            r_pcnt  <= '0;
            r_delay <= '0;
            r_to    <= '0;
            r_gcnt  <= 2'd2;
            r_low   <= 1'b1;
            r_full  <= 1'b0;
            r_sys   <= 1'b0;
            r_board <= 1'b0;
            r_arm   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sys   <= 1'b0;
            r_board <= 1'b0;
            r_arm   <= 1'b0;
            r_to    <= (r_state == IDLE || rx_valid) ? '0 : r_to + 1'b1;
            r_gcnt  <= w_fire ? 2'd0 : (r_gcnt == 2'd2 ? 2'd2 : r_gcnt + 2'd1);
            r_low   <= w_fire ? 1'b0 : (r_low || !tx_rdy);
            if (w_fire) r_full <= 1'b0;
            if (rx_valid) begin
                case (r_state)
                    IDLE: r_rem <= rx_data;
                    CMD: begin
                        r_op    <= rx_data;
                        r_sys   <= rx_data == 8'hFF;
                        r_board <= rx_data == 8'hFE;
                        r_arm   <= rx_data == 8'hFC;
                    end
                    ARG: begin
                        if (r_op == 8'h10) r_width <= rx_data;
                        if (r_op == 8'h11) r_pcnt <= rx_data;
                        if (r_op[7:4] == 4'h2) r_delay[{r_op[1:0], 3'b000} +: 8] <= rx_data;
                    end
                    default: begin
                        if (r_rem != 8'h00) begin
                            r_rem <= r_rem - 8'h01;
                            if (r_full && !w_fire) r_ovr <= 1'b1;
                            else begin
                                r_buf  <= rx_data;
                                r_full <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed bench for cmd_decoder with a simple uart_tx ready model.
module tb_cmd_decoder;
    localparam int TO = 24000;
    logic        clk = 1'b0, rst_n = 1'b1, rx_valid = 1'b0, tx_hold = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  tx_data, width, pulse_cnt;
    logic [31:0] delay;
    logic        tx_en, tx_rdy, sys_rst_req, board_rst_req, glitch_arm, overrun;
    int          busy = 0, n_pass = 0, n_total = 0;
    int          n_sys = 0, n_board = 0, n_arm = 0, excl_err = 0, bad_tx = 0;
    logic [31:0] hist = 32'h0;
    logic [7:0]  txq[$];
    string       s = "Synchronized\r\n";

    always #5 clk = ~clk;
    assign tx_rdy = busy == 0 && !tx_hold;

    cmd_decoder dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_en(tx_en), .tx_rdy(tx_rdy), .width(width),
        .pulse_cnt(pulse_cnt), .delay(delay), .sys_rst_req(sys_rst_req),
        .board_rst_req(board_rst_req), .glitch_arm(glitch_arm), .overrun(overrun)
    );

    // uart_tx stand-in: ready drops for 4 cycles after each load
    always @(posedge clk) begin
        if (tx_en === 1'b1) begin
            txq.push_back(tx_data);
            busy <= 4;
            if (!tx_rdy) bad_tx <= bad_tx + 1;
        end else if (busy > 0) busy <= busy - 1;
        if ($countones({sys_rst_req, board_rst_req, glitch_arm}) > 1) excl_err <= excl_err + 1;
        if (sys_rst_req === 1'b1) begin n_sys <= n_sys + 1; hist <= {hist[27:0], 4'h1}; end
        if (board_rst_req === 1'b1) begin n_board <= n_board + 1; hist <= {hist[27:0], 4'h2}; end
        if (glitch_arm === 1'b1) begin n_arm <= n_arm + 1; hist <= {hist[27:0], 4'h3}; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tx_en"}, tx_en, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_width"}, width, 0);
        chk({tag, "_pulse_cnt"}, pulse_cnt, 0);
        chk({tag, "_delay"}, delay, 0);
        chk({tag, "_strobes"}, {sys_rst_req, board_rst_req, glitch_arm}, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        // strobes
        send(8'h00, 0); send(8'hFF, 0);
        chk("sys_latency", sys_rst_req, 1);
        @(negedge clk);
        chk("sys_one_cycle", sys_rst_req, 0);
        send(8'h00, 0); send(8'hFE, 2);
        send(8'h00, 0); send(8'hFC, 3);
        chk("n_sys", n_sys, 1);
        chk("n_board", n_board, 1);
        chk("n_arm", n_arm, 1);
        chk("strobe_order", hist, 32'h123);
        chk("no_tx_on_cmd", txq.size(), 0);
        // config registers
        send(8'h00, 0); send(8'h10, 0); send(8'h02, 0);
        chk("width", width, 8'h02);
        send(8'h00, 0); send(8'h11, 0); send(8'h5A, 0);
        chk("pulse_cnt_5a", pulse_cnt, 8'h5A);
        send(8'h00, 0); send(8'h11, 0); send(8'h00, 0);
        chk("pulse_cnt_00", pulse_cnt, 8'h00);
        send(8'h00, 0); send(8'h20, 0); send(8'hC8, 0);
        chk("delay_b0", delay, 32'h0000_00C8);
        send(8'h00, 0); send(8'h23, 0); send(8'hAB, 0);
        chk("delay_b3", delay, 32'hAB00_00C8);
        send(8'h00, 0); send(8'h33, 3);
        chk("unknown_width", width, 8'h02);
        chk("unknown_delay", delay, 32'hAB00_00C8);
        chk("unknown_no_strobe", hist, 32'h123);
        // single-byte pass-through
        txq.delete();
        send(8'h01, 2); send(8'h3F, 10);
        chk("pass1_count", txq.size(), 1);
        chk("pass1_byte", txq.size() > 0 ? txq[0] : 8'hxx, 8'h3F);
        send(8'h00, 0); send(8'hFC, 3);
        chk("arm_after_pass", hist, 32'h1233);
        // 14-byte payload at UART pace
        txq.delete();
        send(8'h0E, 12);
        for (int i = 0; i < 14; i++) send(s[i], 12);
        repeat (10) @(negedge clk);
        chk("sync_count", txq.size(), 14);
        for (int i = 0; i < 14; i++)
            chk($sformatf("sync_byte%0d", i), i < txq.size() ? txq[i] : 8'hxx, s[i]);
        chk("sync_overrun", overrun, 0);
        // zero bytes are data inside a payload
        txq.delete();
        send(8'h03, 12);
        for (int i = 0; i < 3; i++) send(8'h00, 12);
        repeat (10) @(negedge clk);
        chk("zeros_count", txq.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("zero_byte%0d", i), i < txq.size() ? txq[i] : 8'hxx, 8'h00);
        chk("zeros_no_strobe", hist, 32'h1233);
        // overrun while uart_tx is busy
        txq.delete();
        tx_hold = 1'b1;
        send(8'h02, 3); send(8'h41, 3); send(8'h42, 3);
        chk("ovr_set", overrun, 1);
        chk("ovr_no_tx", txq.size(), 0);
        chk("ovr_held", tx_data, 8'h41);
        tx_hold = 1'b0;
        repeat (10) @(negedge clk);
        chk("ovr_drain_count", txq.size(), 1);
        chk("ovr_drain_byte", txq.size() > 0 ? txq[0] : 8'hxx, 8'h41);
        send(8'h00, 0); send(8'hFC, 3);
        chk("ovr_then_idle", hist, 32'h12333);
        // frame timeout, then reset mid-payload
        txq.delete();
        send(8'h00, 0); send(8'h10, 0);
        repeat (TO + 1) @(negedge clk);
        send(8'h05, 12);
        chk("timeout_width", width, 8'h02);
        send(8'h00, 12); send(8'h77, 12);
        chk("timeout_pass_count", txq.size(), 2);
        chk("timeout_pass_b0", txq.size() > 0 ? txq[0] : 8'hxx, 8'h00);
        chk("timeout_pass_b1", txq.size() > 1 ? txq[1] : 8'hxx, 8'h77);
        chk("timeout_no_strobe", hist, 32'h12333);
        tx_hold = 1'b1;
        send(8'h88, 2);
        chk("pre_reset_buf", tx_data, 8'h88);
        chk("pre_reset_ovr", overrun, 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tx_hold = 1'b0;
        send(8'h00, 0); send(8'hFC, 3);
        chk("post_reset_arm", hist, 32'h123333);
        chk("post_reset_no_tx", txq.size(), 2);
        chk("strobe_exclusive", excl_err, 0);
        chk("tx_en_while_busy", bad_tx, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cmd_decoder.md
Name: cmd_decoder

Overview:
- Command/stream decoder sitting between the host-side uart_rx and the rest of the glitcher core. It is the responder to the host byte protocol.
- Parses escaped command frames (0x00 followed by an opcode, with an optional argument byte) into config registers and one-cycle strobes.
- Forwards length-prefixed payloads byte-by-byte to the target-side uart_tx.

Parameters:
- TIMEOUT_CYCLES, 24000: idle cycles allowed between bytes of one frame before the frame is aborted.
- TO_W, 16: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to target uart_tx
- tx_en  out  1  one-cycle load strobe to uart_tx
- tx_rdy  in  1  uart_tx idle/ready
- width  out  8  glitch pulse width
- pulse_cnt  out  8  number of glitch pulses
- delay  out  32  glitch delay in cycles
- sys_rst_req  out  1  one-cycle strobe, opcode 0xFF
- board_rst_req  out  1  one-cycle strobe, opcode 0xFE
- glitch_arm  out  1  one-cycle strobe, opcode 0xFC
- overrun  out  1  sticky: a pass-through byte was dropped

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs are 0, except delay = 0 and tx_data = 0. Registers are cleared. Reset asserted mid-frame discards the frame.
- State IDLE, on rx_valid:
  - byte 0x00 -> CMD.
  - byte N (1..255) -> PASS with remaining = N.
- State CMD, on rx_valid:
  - 0xFF -> sys_rst_req = 1 for exactly one cycle (the cycle after rx_valid), then IDLE.
  - 0xFE -> board_rst_req strobe, then IDLE.
  - 0xFC -> glitch_arm strobe, then IDLE.
  - 0x10, 0x11, 0x20-0x23 -> latch opcode, go to ARG.
  - Any other opcode -> ignored, IDLE, no output change.
- State ARG, on rx_valid, by latched opcode:
  - 0x10 -> width <= rx_data.
  - 0x11 -> pulse_cnt <= rx_data.
  - 0x2k -> delay[8k+7:8k] <= rx_data; other delay bytes are unchanged.
  - Registers update on the cycle after rx_valid. Then IDLE.
- State PASS:
  - Each rx_valid byte is written into a one-byte holding buffer; remaining is decremented.
  - When the buffer is full and tx_rdy = 1: assert tx_en for one cycle with tx_data = buffer, and mark the buffer empty.
  - tx_en is never asserted while tx_rdy = 0.
  - After tx_en, no new tx_en is issued until tx_rdy has been observed low and then high again, or for 2 cycles, whichever is longer. This covers uart_tx rdy latency.
  - If rx_valid arrives while the buffer is still full: the new byte is dropped, overrun is set (sticky until reset), and remaining is still decremented.
  - When remaining reaches 0 and the buffer has been drained -> IDLE.
  - Byte values 0x00 inside PASS are data, not escapes.
- Timeout:
  - Counter clears on every rx_valid and in IDLE; otherwise it counts in CMD, ARG and PASS.
  - On reaching TIMEOUT_CYCLES -> IDLE. A pending buffered byte is still drained. Registers are unchanged, and no strobe is issued for the aborted frame.
- Strobes are mutually exclusive. At most one of sys_rst_req, board_rst_req or glitch_arm is high in any cycle.
- Latency: strobe or register update is 1 cycle after the rx_valid of the final frame byte. tx_en follows at the earliest 1 cycle after the byte enters the buffer.
- rx_valid held for more than 1 cycle is treated as multiple bytes. uart_rx guarantees one-cycle pulses.

Test Plan:
- Send 00 FF, then 00 FE, then 00 FC -> exactly one one-cycle pulse each of sys_rst_req, board_rst_req and glitch_arm, in that order; no tx_en.
- Send 00 10 02, 00 11 00, 00 20 C8 -> width = 0x02, pulse_cnt = 0x00, delay = 0x000000C8; then 00 23 AB -> delay = 0xAB0000C8.
- Send 01 3F with tx_rdy toggling like uart_tx -> single tx_en with tx_data = 0x3F, state returns to IDLE; a following 00 FC gives glitch_arm.
- Send 0E "Synchronized\r\n" at UART byte rate -> 14 tx_en pulses with matching bytes in order, overrun = 0. Repeat with a length-3 payload 00 00 00 -> three 0x00 bytes forwarded, no strobes.
- Hold tx_rdy = 0 and send 02 41 42 -> 0x41 held in the buffer, 0x42 dropped, overrun = 1. On tx_rdy = 1, one tx_en with 0x41, then IDLE.
- Send 00 10 then stall TIMEOUT_CYCLES+1 cycles, then 05 -> width unchanged, 05 parsed as length 5 and enters PASS. Assert rst_n low mid-PASS -> all outputs 0 immediately.
